// File: rtl/sb_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sb_capture_fifo
// Brief   : Monitor-side capture FIFO that buffers DUT transactions for a
//           scoreboard, with drop counting and lost-entry marking.
//           Optional macro SB_CAPTURE_TS_EN adds per-entry capture timestamps.
// Revision: 1.0 - initial release
// ============================================================================
module sb_capture_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 16,
    parameter int TS_W         = 16,
    parameter int STOP_ON_DROP = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     mon_valid,
    input  logic [DATA_W-1:0]        mon_data,
    output logic                     drain_valid,
    input  logic                     drain_ready,
    output logic [DATA_W-1:0]        drain_data,
    output logic [TS_W-1:0]          drain_ts,
    output logic                     drain_lost,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt,
    output logic                     halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        drop_q;
    logic              lost_q;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_lost [DEPTH];

    logic w_pop, w_full, w_run, w_push, w_drop;

    assign w_pop  = (count_q != '0) && drain_ready;
    assign w_full = (count_q == C_DEPTH);
    assign w_run  = (state_q == ST_RUN);
    // A pop frees a slot in the same cycle, so a full buffer still accepts.
    assign w_push = w_run && mon_valid && (!w_full || w_pop) && !flush;
    assign w_drop = w_run && mon_valid && w_full && !w_pop && !flush;

    assign count_d = count_q + CW'(w_push) - CW'(w_pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (!enable)
                    state_d = ST_IDLE;
                else if ((STOP_ON_DROP != 0) && w_drop)
                    state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!enable)
                    state_d = ST_IDLE;
                else if (flush)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            lost_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                drop_q   <= '0;
                lost_q   <= 1'b0;
            end else begin
                if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_d;
                if (w_drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
                if (w_drop)
                    lost_q <= 1'b1;
                else if (w_push)
                    lost_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_data[wr_ptr_q] <= mon_data;
            mem_lost[wr_ptr_q] <= lost_q;
        end
    end

    // Head outputs are forced to zero when empty so reset/flush show clean values.
    assign drain_valid = (count_q != '0);
    assign drain_data  = drain_valid ? mem_data[rd_ptr_q] : '0;
    assign drain_lost  = drain_valid ? mem_lost[rd_ptr_q] : 1'b0;
    assign count       = count_q;
    assign drop_cnt    = drop_q;
    assign halted      = (state_q == ST_HALT);

`ifdef SB_CAPTURE_TS_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_ts[wr_ptr_q] <= ts_q;
    end

    assign drain_ts = drain_valid ? mem_ts[rd_ptr_q] : '0;
`else
    assign drain_ts = '0;
`endif

endmodule
`default_nettype wire

// File: doc/sb_capture_fifo.md
SB_CAPTURE_FIFO -- requirements
Module: sb_capture_fifo

Interface
REQ-001 Parameter DATA_W, default 32, monitored transaction payload width.
REQ-002 Parameter DEPTH, default 16, buffer entries; power of two, 2..256.
REQ-003 Parameter TS_W, default 16, timestamp width.
REQ-004 Parameter STOP_ON_DROP, default 0; 1 = halt capture after the first dropped transaction.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 enable  in  1  level; 1 = capture armed.
REQ-009 flush  in  1  synchronous clear of buffer, drop count and lost flag.
REQ-010 mon_valid  in  1  DUT transaction present this cycle.
REQ-011 mon_data  in  DATA_W  DUT transaction payload.
REQ-012 drain_valid  out  1  head entry available to scoreboard side.
REQ-013 drain_ready  in  1  scoreboard side accepts head entry.
REQ-014 drain_data  out  DATA_W  head entry payload.
REQ-015 drain_ts  out  TS_W  head entry capture timestamp.
REQ-016 drain_lost  out  1  one or more transactions were dropped immediately before the head entry.
REQ-017 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-018 drop_cnt  out  8  dropped transactions, saturating at 255.
REQ-019 halted  out  1  state is HALT.

Function
REQ-020 States SHALL be IDLE, RUN and HALT.
REQ-021 IDLE->RUN when enable=1; RUN->IDLE and HALT->IDLE when enable=0; RUN->HALT on a drop when STOP_ON_DROP=1; HALT->RUN on flush while enable=1.
REQ-022 In RUN, mon_valid=1 with count<DEPTH SHALL write {mon_data, timestamp, lost flag} at that edge.
REQ-023 A written entry SHALL appear on drain_* in the cycle after the write edge (first-word fall-through, one-cycle latency).
REQ-024 In RUN, mon_valid=1 with count=DEPTH and no pop that cycle SHALL drop the transaction, increment drop_cnt (saturating) and set the internal lost flag.
REQ-025 A push and a pop in the same cycle at count=DEPTH SHALL both succeed, leaving count unchanged and dropping nothing.
REQ-026 The lost flag SHALL be stored with the next accepted entry and then cleared.
REQ-027 mon_valid in IDLE or HALT SHALL be ignored and SHALL NOT be counted as a drop.
REQ-028 drain_valid = (count!=0); a pop occurs on drain_valid&&drain_ready; drain_ready while empty has no effect.
REQ-029 Entries already buffered SHALL remain drainable in IDLE and HALT.
REQ-030 The timestamp counter SHALL increment every cycle from reset, independent of state, and wrap from 2^TS_W-1 to 0.
REQ-031 flush SHALL take priority over a same-cycle push and pop: count=0, drop_cnt=0, lost flag=0 after the edge, and the same-cycle push is discarded.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 On rst: state IDLE, count 0, drain_valid 0, drain_data 0, drain_ts 0, drain_lost 0, drop_cnt 0, halted 0, timestamp 0, pointers 0.
REQ-034 rst asserted mid-capture SHALL discard all buffered entries immediately without waiting for a clock edge.

Configuration
REQ-035 Macro SB_CAPTURE_TS_EN defined: timestamp counter and per-entry timestamp storage are present as specified.
REQ-036 SB_CAPTURE_TS_EN undefined: no timestamp counter or storage; drain_ts SHALL be constant 0; all other behaviour unchanged.

Verification
REQ-037 Reset, enable=1, push 0xA5A5_0001 at timestamp 5 -> next cycle drain_valid=1, drain_data=0xA5A5_0001, drain_ts=5, drain_lost=0, count=1.
REQ-038 DEPTH=16, drain_ready=0, 18 consecutive pushes -> count=16, drop_cnt=2; drain 16 entries in order; next accepted entry has drain_lost=1.
REQ-039 Full buffer, push and pop in the same cycle -> count stays 16, drop_cnt unchanged, new entry appears last.
REQ-040 STOP_ON_DROP=1, overflow by one push -> halted=1, further mon_valid ignored and drop_cnt=1; flush with enable=1 -> RUN, count=0, drop_cnt=0.
REQ-041 TS_W=4, capture at cycles 14 and 17 -> drain_ts values 14 and 1; with SB_CAPTURE_TS_EN undefined -> drain_ts=0 for both.
REQ-042 rst pulsed with count=5 -> count=0 and drain_valid=0 before the next edge; state IDLE.
